// File: rtl/tor_network_emulator.sv
// Top-of-rack network emulator: per-ingress FIFOs, destination routing,
// per-egress round-robin arbitration and a fixed-latency delay line.
//
// Ports:
//   clk                  network clock
//   reset                synchronous, active-high
//   network_tx_in        NUM_PORTS packet words, slice i from NIC i
//   network_tx_valid_in  per-ingress strobe, no backpressure
//   network_rx_out       NUM_PORTS packet words, slice j to NIC j
//   network_rx_valid_out per-egress strobe
//   drop_cnt_out         per-ingress wrapping count of dropped packets
module tor_network_emulator #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned DEST_LSB   = 0,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] network_tx_in,
    input  logic [NUM_PORTS-1:0]            network_tx_valid_in,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] network_rx_out,
    output logic [NUM_PORTS-1:0]            network_rx_valid_out,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]  drop_cnt_out
);

    localparam int unsigned DW = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned SW = DW + 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned FW = AW + 1;

    // State
    logic [DATA_WIDTH-1:0] fifo_mem [NUM_PORTS][FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr   [NUM_PORTS];
    logic [AW-1:0]         wr_ptr   [NUM_PORTS];
    logic [FW-1:0]         fill     [NUM_PORTS];
    logic [DW-1:0]         rr_ptr   [NUM_PORTS];
    logic [CNT_WIDTH-1:0]  drop_cnt [NUM_PORTS];
    logic [NUM_PORTS-1:0]  dl_valid [LATENCY];
    logic [DATA_WIDTH-1:0] dl_data  [LATENCY][NUM_PORTS];

    // Combinational
    logic [DATA_WIDTH-1:0] in_word   [NUM_PORTS];
    logic [DATA_WIDTH-1:0] head      [NUM_PORTS];
    logic [NUM_PORTS-1:0]  head_req  [NUM_PORTS];
    logic [DW-1:0]         gnt_idx   [NUM_PORTS];
    logic [DATA_WIDTH-1:0] st0_data  [NUM_PORTS];
    logic [NUM_PORTS-1:0]  gnt_valid;
    logic [NUM_PORTS-1:0]  pop;
    logic [NUM_PORTS-1:0]  push;
    logic [NUM_PORTS-1:0]  drop;

    // FIFO heads and the single egress each non-empty head requests
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            head[i]     = fifo_mem[i][rd_ptr[i]];
            head_req[i] = '0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                head_req[i][j] = (fill[i] != '0) &&
                                 (head[i][DEST_LSB +: DW] == DW'(j));
            end
        end
    end

    // Per-egress round-robin: scan ingresses starting at rr_ptr
    always_comb begin
        logic [SW-1:0] sum;
        sum       = '0;
        gnt_valid = '0;
        pop       = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            gnt_idx[j] = '0;
            for (int off = 0; off < NUM_PORTS; off++) begin
                sum = {1'b0, rr_ptr[j]} + SW'(off);
                if (sum >= SW'(NUM_PORTS)) begin
                    sum = sum - SW'(NUM_PORTS);
                end
                if (!gnt_valid[j] && head_req[sum[DW-1:0]][j]) begin
                    gnt_valid[j] = 1'b1;
                    gnt_idx[j]   = sum[DW-1:0];
                end
            end
            st0_data[j] = gnt_valid[j] ? head[gnt_idx[j]] : '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (gnt_valid[j] && (gnt_idx[j] == DW'(i))) begin
                    pop[i] = 1'b1;
                end
            end
        end
    end

    // Ingress admission: a full FIFO still accepts when its head leaves this cycle
    always_comb begin
        logic [DW-1:0] in_dest;
        logic          dest_ok;
        logic          full;
        in_dest = '0;
        dest_ok = 1'b0;
        full    = 1'b0;
        push    = '0;
        drop    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            in_word[i] = network_tx_in[i*DATA_WIDTH +: DATA_WIDTH];
            in_dest    = in_word[i][DEST_LSB +: DW];
            dest_ok    = {1'b0, in_dest} < SW'(NUM_PORTS);
            full       = fill[i] == FW'(FIFO_DEPTH);
            push[i]    = network_tx_valid_in[i] && dest_ok && (!full || pop[i]);
            drop[i]    = network_tx_valid_in[i] && !push[i];
        end
    end

    // FIFO storage; contents need no reset since pointers gate every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!reset && push[i]) begin
                fifo_mem[i][wr_ptr[i]] <= in_word[i];
            end
        end
    end

    // Pointers, occupancy, arbiter state, drop counters and delay line
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                rd_ptr[i]   <= '0;
                wr_ptr[i]   <= '0;
                fill[i]     <= '0;
                rr_ptr[i]   <= '0;
                drop_cnt[i] <= '0;
            end
            for (int s = 0; s < LATENCY; s++) begin
                dl_valid[s] <= '0;
                for (int j = 0; j < NUM_PORTS; j++) begin
                    dl_data[s][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   fill[i] <= fill[i] + FW'(1);
                    2'b01:   fill[i] <= fill[i] - FW'(1);
                    default: fill[i] <= fill[i];
                endcase
                if (drop[i]) begin
                    drop_cnt[i] <= drop_cnt[i] + CNT_WIDTH'(1);
                end
            end
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (gnt_valid[j]) begin
                    rr_ptr[j] <= (gnt_idx[j] == DW'(NUM_PORTS - 1)) ? '0
                                                                     : gnt_idx[j] + DW'(1);
                end
                dl_data[0][j] <= st0_data[j];
            end
            dl_valid[0] <= gnt_valid;
            for (int s = 1; s < LATENCY; s++) begin
                dl_valid[s] <= dl_valid[s-1];
                for (int j = 0; j < NUM_PORTS; j++) begin
                    dl_data[s][j] <= dl_data[s-1][j];
                end
            end
        end
    end

    // Outputs come straight from the last delay stage and the counters
    always_comb begin
        network_rx_valid_out = dl_valid[LATENCY-1];
        for (int j = 0; j < NUM_PORTS; j++) begin
            network_rx_out[j*DATA_WIDTH +: DATA_WIDTH] = dl_data[LATENCY-1][j];
            drop_cnt_out[j*CNT_WIDTH +: CNT_WIDTH]     = drop_cnt[j];
        end
    end

endmodule

// File: tb/tb_tor_network_emulator.sv
// Self-checking bench for tor_network_emulator (3 ports, depth-4 FIFOs, latency 3).
// Packet word layout: [15:14] source, [13:6] sequence, [5:4] destination, [3:0] filler.
module tb_tor_network_emulator;

    localparam int NP  = 3;
    localparam int DWD = 16;
    localparam int DL  = 4;
    localparam int FD  = 4;
    localparam int LAT = 3;
    localparam int CW  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*DWD-1:0] tx;
    logic [NP-1:0]     txv;
    logic [NP*DWD-1:0] rx;
    logic [NP-1:0]     rxv;
    logic [NP*CW-1:0]  cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    tor_network_emulator #(
        .NUM_PORTS (NP),
        .DATA_WIDTH(DWD),
        .DEST_LSB  (DL),
        .FIFO_DEPTH(FD),
        .LATENCY   (LAT),
        .CNT_WIDTH (CW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .network_tx_in       (tx),
        .network_tx_valid_in (txv),
        .network_rx_out      (rx),
        .network_rx_valid_out(rxv),
        .drop_cnt_out        (cnt)
    );

    // Reference model: queues per ingress, round-robin pointer per egress,
    // and a LAT-deep pipe of what each egress emits.
    logic [DWD-1:0] mf   [NP][FD];
    int             mn   [NP];
    int             mptr [NP];
    logic           mpv  [LAT][NP];
    logic [DWD-1:0] mpd  [LAT][NP];
    logic [CW-1:0]  mdrop[NP];

    always @(posedge clk) begin : ref_model
        int             k;
        logic           gv [NP];
        int             gk [NP];
        logic [DWD-1:0] gw [NP];
        logic [DWD-1:0] inw;
        if (reset) begin
            for (int i = 0; i < NP; i++) begin
                mn[i] = 0; mptr[i] = 0; mdrop[i] = '0;
                for (int s = 0; s < LAT; s++) begin
                    mpv[s][i] = 1'b0; mpd[s][i] = '0;
                end
            end
        end else begin
            for (int j = 0; j < NP; j++) begin
                gv[j] = 1'b0; gk[j] = 0; gw[j] = '0;
                for (int off = 0; off < NP; off++) begin
                    k = (mptr[j] + off) % NP;
                    if (!gv[j] && mn[k] > 0 && int'(mf[k][0][DL +: 2]) == j) begin
                        gv[j] = 1'b1; gk[j] = k;
                    end
                end
            end
            for (int j = 0; j < NP; j++) begin
                if (gv[j]) begin
                    gw[j] = mf[gk[j]][0];
                    for (int e = 0; e < FD - 1; e++) mf[gk[j]][e] = mf[gk[j]][e+1];
                    mn[gk[j]] = mn[gk[j]] - 1;
                    mptr[j] = (gk[j] + 1) % NP;
                end
            end
            for (int i = 0; i < NP; i++) begin
                if (txv[i]) begin
                    inw = tx[i*DWD +: DWD];
                    if (int'(inw[DL +: 2]) >= NP || mn[i] == FD) begin
                        mdrop[i] = mdrop[i] + CW'(1);
                    end else begin
                        mf[i][mn[i]] = inw;
                        mn[i] = mn[i] + 1;
                    end
                end
            end
            for (int s = LAT - 1; s > 0; s--) begin
                for (int j = 0; j < NP; j++) begin
                    mpv[s][j] = mpv[s-1][j]; mpd[s][j] = mpd[s-1][j];
                end
            end
            for (int j = 0; j < NP; j++) begin
                mpv[0][j] = gv[j]; mpd[0][j] = gw[j];
            end
        end
    end

    function automatic logic [DWD-1:0] mk(int src, int seq, int dest);
        return {2'(src), 8'(seq), 2'(dest), 4'($urandom)};
    endfunction

    function automatic logic [DWD-1:0] rxw(int j);
        return rx[j*DWD +: DWD];
    endfunction

    function automatic logic [CW-1:0] cntw(int i);
        return cnt[i*CW +: CW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        txv = '0;
        for (int i = 0; i < NP; i++) tx[i*DWD +: DWD] = 16'($urandom);
    endtask

    task automatic send(int i, logic [DWD-1:0] w);
        tx[i*DWD +: DWD] = w;
        txv[i] = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        txv = '1;
        for (int i = 0; i < NP; i++) tx[i*DWD +: DWD] = mk(i, 0, 0);
        tick(); tick();
        nvec++; if (rxv !== '0) begin nerr++; $display("FAIL reset_valid: got %b expected 0", rxv); end
        nvec++; if (rx !== '0) begin nerr++; $display("FAIL reset_data: got %h expected 0", rx); end
        nvec++; if (cnt !== '0) begin nerr++; $display("FAIL reset_cnt: got %h expected 0", cnt); end
        reset = 1'b0;
        idle();
        for (int k = 1; k <= LAT + 3; k++) begin
            tick();
            nvec++; if (rxv !== '0) begin nerr++; $display("FAIL reset_discard k=%0d: got %b expected 0", k, rxv); end
        end
        nvec++; if (cnt !== '0) begin nerr++; $display("FAIL reset_nocount: got %h expected 0", cnt); end
    endtask

    task automatic test_single();
        logic [DWD-1:0] w;
        logic [NP-1:0]  ev;
        w = mk(0, 1, 1);
        send(0, w);
        for (int k = 1; k <= LAT + 4; k++) begin
            tick();
            if (k == 1) idle();
            ev = (k == LAT + 1) ? 3'b010 : 3'b000;
            nvec++; if (rxv !== ev) begin nerr++; $display("FAIL single_valid k=%0d: got %b expected %b", k, rxv, ev); end
            if (k == LAT + 1) begin
                nvec++; if (rxw(1) !== w) begin nerr++; $display("FAIL single_data: got %h expected %h", rxw(1), w); end
            end
        end
    endtask

    task automatic test_contention();
        logic [DWD-1:0] w [NP];
        logic [NP-1:0]  ev;
        for (int i = 0; i < NP; i++) begin
            w[i] = mk(i, 2, 0);
            send(i, w[i]);
        end
        for (int k = 1; k <= LAT + 6; k++) begin
            tick();
            if (k == 1) idle();
            ev = (k >= LAT + 1 && k <= LAT + NP) ? 3'b001 : 3'b000;
            nvec++; if (rxv !== ev) begin nerr++; $display("FAIL contention_valid k=%0d: got %b expected %b", k, rxv, ev); end
            if (ev[0]) begin
                nvec++;
                if (rxw(0) !== w[k-LAT-1]) begin
                    nerr++; $display("FAIL contention_order k=%0d: got %h expected %h", k, rxw(0), w[k-LAT-1]);
                end
            end
        end
    endtask

    task automatic test_bad_dest();
        send(1, mk(1, 3, 3));
        for (int k = 1; k <= LAT + 3; k++) begin
            tick();
            if (k == 1) begin
                idle();
                nvec++;
                if (cntw(0) !== 8'd0 || cntw(1) !== 8'd1 || cntw(2) !== 8'd0) begin
                    nerr++; $display("FAIL bad_dest_cnt: got %h expected 000100", cnt);
                end
            end
            nvec++; if (rxv !== '0) begin nerr++; $display("FAIL bad_dest_quiet k=%0d: got %b expected 0", k, rxv); end
        end
    endtask

    // Ingress 0 and 1 both stream to egress 2 for 20 cycles; each FIFO drains
    // every other cycle, so both fill and then drop on alternate cycles.
    task automatic test_fairness_overflow();
        int   got [2];
        int   last_seq [2];
        int   psrc;
        int   s, q;
        got = '{0, 0}; last_seq = '{0, 0}; psrc = -1;
        for (int k = 1; k <= 45; k++) begin
            if (k <= 20) begin
                send(0, mk(0, k, 2)); send(1, mk(1, k, 2));
            end else begin
                idle();
            end
            tick();
            if (k <= 2 * FD - 1) begin
                nvec++;
                if (cntw(0) !== 8'd0 || cntw(1) !== 8'd1) begin
                    nerr++; $display("FAIL fair_early_drop k=%0d: got %h expected 000100", k, cnt);
                end
            end
            nvec++; if (rxv[1:0] !== 2'b00) begin nerr++; $display("FAIL fair_stray k=%0d: got %b expected 0", k, rxv); end
            if (rxv[2]) begin
                s = int'(rxw(2)[15:14]);
                q = int'(rxw(2)[13:6]);
                nvec++;
                if (s == psrc || s > 1) begin
                    nerr++; $display("FAIL fair_alternate k=%0d: got src %0d expected not %0d", k, s, psrc);
                end else begin
                    nvec++;
                    if (q <= last_seq[s]) begin
                        nerr++; $display("FAIL fair_order k=%0d: got seq %0d expected > %0d", k, q, last_seq[s]);
                    end
                    last_seq[s] = q;
                    got[s]++;
                end
                psrc = s;
            end
        end
        nvec++; if (cntw(0) !== 8'd6) begin nerr++; $display("FAIL overflow_cnt0: got %0d expected 6", cntw(0)); end
        nvec++; if (cntw(1) !== 8'd8) begin nerr++; $display("FAIL overflow_cnt1: got %0d expected 8", cntw(1)); end
        nvec++; if (got[0] != 14) begin nerr++; $display("FAIL overflow_deliv0: got %0d expected 14", got[0]); end
        nvec++; if (got[1] != 13) begin nerr++; $display("FAIL overflow_deliv1: got %0d expected 13", got[1]); end
        for (int i = 0; i < NP; i++) begin
            nvec++; if (cntw(i) !== mdrop[i]) begin nerr++; $display("FAIL overflow_model%0d: got %0d expected %0d", i, cntw(i), mdrop[i]); end
        end
    endtask

    task automatic test_reset_midflight();
        logic [DWD-1:0] w0, w1;
        logic [NP-1:0]  ev;
        for (int c = 1; c <= 3; c++) begin
            idle();
            if (c == 1) send(0, mk(0, 1, 0));
            send(1, mk(1, c, 1)); send(2, mk(2, c, 1));
            tick();
        end
        idle();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nvec++; if (rxv !== '0) begin nerr++; $display("FAIL midreset_valid: got %b expected 0", rxv); end
        nvec++; if (cnt !== '0) begin nerr++; $display("FAIL midreset_cnt: got %h expected 0", cnt); end
        for (int k = 1; k <= LAT + 4; k++) begin
            tick();
            nvec++; if (rxv !== '0) begin nerr++; $display("FAIL midreset_flush k=%0d: got %b expected 0", k, rxv); end
        end
        // ptr[0] was 1 before reset; after reset ingress 0 must win first
        w0 = mk(0, 9, 0); w1 = mk(1, 9, 0);
        send(0, w0); send(1, w1);
        for (int k = 1; k <= LAT + 4; k++) begin
            tick();
            if (k == 1) idle();
            ev = (k == LAT + 1 || k == LAT + 2) ? 3'b001 : 3'b000;
            nvec++; if (rxv !== ev) begin nerr++; $display("FAIL midreset_lat k=%0d: got %b expected %b", k, rxv, ev); end
            if (k == LAT + 1) begin
                nvec++; if (rxw(0) !== w0) begin nerr++; $display("FAIL midreset_ptr0: got %h expected %h", rxw(0), w0); end
            end
            if (k == LAT + 2) begin
                nvec++; if (rxw(0) !== w1) begin nerr++; $display("FAIL midreset_ptr1: got %h expected %h", rxw(0), w1); end
            end
        end
    endtask

    task automatic test_random();
        int d;
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    d = int'($urandom_range(0, 5));
                    if (d > 3) d = 0;
                    send(i, mk(i, c, d));
                end
            end
            tick();
            for (int j = 0; j < NP; j++) begin
                nvec++;
                if (rxv[j] !== mpv[LAT-1][j]) begin
                    nerr++; $display("FAIL rand_valid c=%0d port %0d: got %b expected %b", c, j, rxv[j], mpv[LAT-1][j]);
                end else if (mpv[LAT-1][j]) begin
                    nvec++;
                    if (rxw(j) !== mpd[LAT-1][j]) begin
                        nerr++; $display("FAIL rand_data c=%0d port %0d: got %h expected %h", c, j, rxw(j), mpd[LAT-1][j]);
                    end
                end
                nvec++;
                if (cntw(j) !== mdrop[j]) begin
                    nerr++; $display("FAIL rand_cnt c=%0d port %0d: got %0d expected %0d", c, j, cntw(j), mdrop[j]);
                end
            end
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        txv = '0;
        tx = '0;
        test_reset();
        test_single();
        test_contention();
        test_bad_dest();
        test_fairness_overflow();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
